// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline bus: ID-side inputs, forwarding sources and registered EX-side outputs.
interface id_ex_stage_if #(
   parameter int DW = 32
);
   logic          dvalid;
   logic [31:0]   dinst;
   logic [DW-1:0] da;
   logic [DW-1:0] db;
   logic          stall;
   logic          flush;
   logic          mwreg;
   logic [4:0]    mrn;
   logic [DW-1:0] malu;
   logic          wwreg;
   logic [4:0]    wrn;
   logic [DW-1:0] wdata;
   logic [3:0]    EALUC;
   logic [DW-1:0] EXA;
   logic [DW-1:0] EXB;
   logic          ewreg;
   logic [4:0]    ern;
   logic          evalid;
   logic          ebad;

   modport master (
      output dvalid, dinst, da, db, stall, flush,
      output mwreg, mrn, malu, wwreg, wrn, wdata,
      input  EALUC, EXA, EXB, ewreg, ern, evalid, ebad
   );

   modport slave (
      input  dvalid, dinst, da, db, stall, flush,
      input  mwreg, mrn, malu, wwreg, wrn, wdata,
      output EALUC, EXA, EXB, ewreg, ern, evalid, ebad
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MIPS-style decode; operand forwarding from
// EX/MEM and MEM/WB is compiled in only when IDEX_FWD_EN is defined.
module id_ex_stage #(
   parameter int DW = 32
) (
   input logic          clock,
   input logic          resetn,
   id_ex_stage_if.slave bus
);
   logic [5:0]    w_op;
   logic [5:0]    w_funct;
   logic          w_rtype;
   logic          w_legal;
   logic          w_shift;
   logic          w_zext;
   logic          w_store;
   logic [3:0]    w_aluc;
   logic [DW-1:0] w_a;
   logic [DW-1:0] w_b;
   logic [DW-1:0] w_imm_s;
   logic [DW-1:0] w_imm_z;
   logic [DW-1:0] w_exa;
   logic [DW-1:0] w_exb;
   logic [4:0]    w_ern;
   logic          w_wreg;

   logic [3:0]    r_aluc;
   logic [DW-1:0] r_exa;
   logic [DW-1:0] r_exb;
   logic          r_wreg;
   logic [4:0]    r_ern;
   logic          r_valid;
   logic          r_bad;

   assign w_op    = bus.dinst[31:26];
   assign w_funct = bus.dinst[5:0];
   assign w_rtype = (w_op == 6'b000000);
   assign w_imm_s = {{(DW-16){bus.dinst[15]}}, bus.dinst[15:0]};
   assign w_imm_z = {{(DW-16){1'b0}}, bus.dinst[15:0]};

`ifdef IDEX_FWD_EN
   logic [4:0] w_rs;
   logic [4:0] w_rt;
   assign w_rs = bus.dinst[25:21];
   assign w_rt = bus.dinst[20:16];

   // EX/MEM result is younger than MEM/WB, so it takes precedence.
   always_comb begin
      w_a = bus.da;
      if (bus.mwreg && (bus.mrn != 5'd0) && (bus.mrn == w_rs))
         w_a = bus.malu;
      else if (bus.wwreg && (bus.wrn != 5'd0) && (bus.wrn == w_rs))
         w_a = bus.wdata;
   end

   always_comb begin
      w_b = bus.db;
      if (bus.mwreg && (bus.mrn != 5'd0) && (bus.mrn == w_rt))
         w_b = bus.malu;
      else if (bus.wwreg && (bus.wrn != 5'd0) && (bus.wrn == w_rt))
         w_b = bus.wdata;
   end
`else
   logic w_unused_fwd;
   assign w_a = bus.da;
   assign w_b = bus.db;
   assign w_unused_fwd = ^{bus.mwreg, bus.mrn, bus.malu, bus.wwreg, bus.wrn, bus.wdata};
`endif

   always_comb begin
      w_aluc  = 4'b0010;
      w_legal = 1'b0;
      w_shift = 1'b0;
      w_zext  = 1'b0;
      w_store = 1'b0;
      if (w_rtype) begin
         w_legal = 1'b1;
         case (w_funct)
            6'b100000: w_aluc = 4'b0010;
            6'b100001: w_aluc = 4'b0011;
            6'b100010: w_aluc = 4'b0110;
            6'b100011: w_aluc = 4'b1110;
            6'b100100: w_aluc = 4'b0000;
            6'b100101: w_aluc = 4'b0001;
            6'b100110: w_aluc = 4'b1100;
            6'b101010: w_aluc = 4'b0111;
            6'b101011: w_aluc = 4'b0101;
            6'b000000: begin w_aluc = 4'b1000; w_shift = 1'b1; end
            6'b000010: begin w_aluc = 4'b1001; w_shift = 1'b1; end
            default:   begin w_aluc = 4'b0010; w_legal = 1'b0; end
         endcase
      end else begin
         w_legal = 1'b1;
         case (w_op)
            6'b001000: w_aluc = 4'b0010;
            6'b001001: w_aluc = 4'b0011;
            6'b001010: w_aluc = 4'b0111;
            6'b001011: w_aluc = 4'b0101;
            6'b001100: begin w_aluc = 4'b0000; w_zext = 1'b1; end
            6'b001101: begin w_aluc = 4'b0001; w_zext = 1'b1; end
            6'b001110: begin w_aluc = 4'b1100; w_zext = 1'b1; end
            6'b001111: w_aluc = 4'b1111;
            6'b100011: w_aluc = 4'b0010;
            6'b101011: begin w_aluc = 4'b0010; w_store = 1'b1; end
            default:   begin w_aluc = 4'b0010; w_legal = 1'b0; end
         endcase
      end
   end

   // Illegal encodings fall back to the plain register-register operand pair.
   always_comb begin
      w_exa = w_a;
      w_exb = w_b;
      if (w_legal && w_rtype && w_shift) begin
         w_exa = w_b;
         w_exb = w_imm_s;
      end else if (w_legal && !w_rtype) begin
         w_exb = w_zext ? w_imm_z : w_imm_s;
      end
   end

   assign w_ern  = w_rtype ? bus.dinst[15:11] : bus.dinst[20:16];
   assign w_wreg = w_legal && !w_store && (w_ern != 5'd0);

   always_ff @(posedge clock) begin
      if (!resetn || bus.flush || (!bus.stall && !bus.dvalid)) begin
         r_aluc  <= 4'b0010;
         r_exa   <= '0;
         r_exb   <= '0;
         r_wreg  <= 1'b0;
         r_ern   <= 5'd0;
         r_valid <= 1'b0;
         r_bad   <= 1'b0;
      end else if (!bus.stall) begin
         r_aluc  <= w_aluc;
         r_exa   <= w_exa;
         r_exb   <= w_exb;
         r_wreg  <= w_wreg;
         r_ern   <= w_ern;
         r_valid <= 1'b1;
         r_bad   <= !w_legal;
      end
   end

   assign bus.EALUC  = r_aluc;
   assign bus.EXA    = r_exa;
   assign bus.EXB    = r_exb;
   assign bus.ewreg  = r_wreg;
   assign bus.ern    = r_ern;
   assign bus.evalid = r_valid;
   assign bus.ebad   = r_bad;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; forwarding expectations follow IDEX_FWD_EN.
module tb_id_ex_stage;
   logic clock = 1'b0;
   logic resetn;
   int   tests = 0;
   int   fails = 0;

   id_ex_stage_if #(.DW(32)) bus ();

   id_ex_stage #(.DW(32)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_all(input string tag, input logic [3:0] aluc,
                             input logic [31:0] exa, input logic [31:0] exb,
                             input logic [4:0] ern, input logic wreg,
                             input logic valid, input logic bad);
      chk({tag, ".EALUC"},  {28'd0, bus.EALUC}, {28'd0, aluc});
      chk({tag, ".EXA"},    bus.EXA, exa);
      chk({tag, ".EXB"},    bus.EXB, exb);
      chk({tag, ".ern"},    {27'd0, bus.ern}, {27'd0, ern});
      chk({tag, ".ewreg"},  {31'd0, bus.ewreg}, {31'd0, wreg});
      chk({tag, ".evalid"}, {31'd0, bus.evalid}, {31'd0, valid});
      chk({tag, ".ebad"},   {31'd0, bus.ebad}, {31'd0, bad});
      $display("[TB] %-10s inst=%h aluc=%h exa=%h exb=%h ern=%0d wreg=%b valid=%b bad=%b",
               tag, bus.dinst, bus.EALUC, bus.EXA, bus.EXB, bus.ern, bus.ewreg, bus.evalid, bus.ebad);
   endtask

   task automatic drive(input logic valid, input logic [31:0] inst,
                        input logic [31:0] a, input logic [31:0] b);
      bus.dvalid = valid;
      bus.dinst  = inst;
      bus.da     = a;
      bus.db     = b;
      @(posedge clock);
      #1;
   endtask

   initial begin
      resetn     = 1'b0;
      bus.stall  = 1'b0;
      bus.flush  = 1'b0;
      bus.mwreg  = 1'b0;
      bus.mrn    = 5'd0;
      bus.malu   = 32'd0;
      bus.wwreg  = 1'b0;
      bus.wrn    = 5'd0;
      bus.wdata  = 32'd0;

      // Reset wins over a valid add
      drive(1'b1, 32'h00430820, 32'd5, 32'd7);
      expect_all("reset", 4'h2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);

      resetn = 1'b1;
      drive(1'b1, 32'h00430820, 32'd5, 32'd7);
      expect_all("add", 4'h2, 32'd5, 32'd7, 5'd1, 1'b1, 1'b1, 1'b0);

      drive(1'b1, 32'h00021080, 32'd9, 32'd3);
      expect_all("sll", 4'h8, 32'd3, 32'h00001080, 5'd2, 1'b1, 1'b1, 1'b0);
      chk("sll.shamt", {27'd0, bus.EXB[10:6]}, 32'd2);

      drive(1'b1, 32'h3C01ABCD, 32'd4, 32'd6);
      expect_all("lui", 4'hF, 32'd4, 32'hFFFFABCD, 5'd1, 1'b1, 1'b1, 1'b0);

      drive(1'b1, 32'h34018000, 32'd0, 32'd6);
      expect_all("ori", 4'h1, 32'd0, 32'h00008000, 5'd1, 1'b1, 1'b1, 1'b0);

      drive(1'b1, 32'h28018000, 32'd0, 32'd6);
      expect_all("slti", 4'h7, 32'd0, 32'hFFFF8000, 5'd1, 1'b1, 1'b1, 1'b0);

      drive(1'b1, 32'hAC410004, 32'h40, 32'h99);
      expect_all("sw", 4'h2, 32'h40, 32'd4, 5'd1, 1'b0, 1'b1, 1'b0);

      drive(1'b1, 32'hFC000000, 32'h12, 32'h34);
      expect_all("bad_op", 4'h2, 32'h12, 32'h34, 5'd0, 1'b0, 1'b1, 1'b1);

      drive(1'b1, 32'h0043083F, 32'h56, 32'h78);
      expect_all("bad_fn", 4'h2, 32'h56, 32'h78, 5'd1, 1'b0, 1'b1, 1'b1);

      // Destination r0 suppresses the write
      drive(1'b1, 32'h00430022, 32'd10, 32'd3);
      expect_all("sub_r0", 4'h6, 32'd10, 32'd3, 5'd0, 1'b0, 1'b1, 1'b0);

      drive(1'b1, 32'h00430821, 32'h100, 32'h200);
      expect_all("addu", 4'h3, 32'h100, 32'h200, 5'd1, 1'b1, 1'b1, 1'b0);

      bus.stall = 1'b1;
      drive(1'b1, 32'h00430822, 32'h111, 32'h222);
      expect_all("stall1", 4'h3, 32'h100, 32'h200, 5'd1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 32'h3C01ABCD, 32'h333, 32'h444);
      expect_all("stall2", 4'h3, 32'h100, 32'h200, 5'd1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 32'hFC000000, 32'h555, 32'h666);
      expect_all("stall3", 4'h3, 32'h100, 32'h200, 5'd1, 1'b1, 1'b1, 1'b0);

      bus.flush = 1'b1;
      drive(1'b1, 32'h00430820, 32'd5, 32'd7);
      expect_all("stl_flush", 4'h2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      bus.stall = 1'b0;
      bus.flush = 1'b0;

      drive(1'b1, 32'h00430826, 32'hA, 32'hB);
      expect_all("xor", 4'hC, 32'hA, 32'hB, 5'd1, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 32'h00430826, 32'hA, 32'hB);
      expect_all("no_valid", 4'h2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);

      // Reset during a stall discards the held instruction
      drive(1'b1, 32'h00430820, 32'd5, 32'd7);
      expect_all("add2", 4'h2, 32'd5, 32'd7, 5'd1, 1'b1, 1'b1, 1'b0);
      bus.stall = 1'b1;
      resetn    = 1'b0;
      drive(1'b1, 32'h00430826, 32'd1, 32'd2);
      expect_all("rst_stall", 4'h2, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      bus.stall = 1'b0;
      resetn    = 1'b1;
      drive(1'b1, 32'h00430824, 32'hF0, 32'h3C);
      expect_all("and", 4'h0, 32'hF0, 32'h3C, 5'd1, 1'b1, 1'b1, 1'b0);

      bus.mwreg = 1'b1;
      bus.mrn   = 5'd2;
      bus.malu  = 32'h11;
      bus.wwreg = 1'b1;
      bus.wrn   = 5'd2;
      bus.wdata = 32'h22;
`ifdef IDEX_FWD_EN
      drive(1'b1, 32'h00430820, 32'h33, 32'h44);
      expect_all("fwd_mem", 4'h2, 32'h11, 32'h44, 5'd1, 1'b1, 1'b1, 1'b0);
      bus.mrn = 5'd0;
      drive(1'b1, 32'h00430820, 32'h33, 32'h44);
      expect_all("fwd_wb", 4'h2, 32'h22, 32'h44, 5'd1, 1'b1, 1'b1, 1'b0);
`else
      drive(1'b1, 32'h00430820, 32'h33, 32'h44);
      expect_all("nofwd_mem", 4'h2, 32'h33, 32'h44, 5'd1, 1'b1, 1'b1, 1'b0);
      bus.mrn = 5'd0;
      drive(1'b1, 32'h00430820, 32'h33, 32'h44);
      expect_all("nofwd_wb", 4'h2, 32'h33, 32'h44, 5'd1, 1'b1, 1'b1, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: DW, 32, operand/result data width (only 32 supported).
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 dvalid  in  1  ID slot holds a valid instruction.
REQ-005 dinst  in  32  instruction word from ID.
REQ-006 da, db  in  32 each  register-file read data for rs (dinst[25:21]) and rt (dinst[20:16]).
REQ-007 stall  in  1  hold all EX-side registers.
REQ-008 flush  in  1  load a bubble.
REQ-009 mwreg, mrn, malu  in  1/5/32  EX/MEM write-enable, destination, result.
REQ-010 wwreg, wrn, wdata  in  1/5/32  MEM/WB write-enable, destination, data.
REQ-011 EALUC  out  4  registered ALU operation code.
REQ-012 EXA, EXB  out  32 each  registered ALU operands.
REQ-013 ewreg, ern  out  1/5  registered register-write enable and destination.
REQ-014 evalid, ebad  out  1 each  registered valid flag; illegal-opcode flag.

Function
REQ-015 Latency: exactly one cycle from ID inputs to all outputs; outputs are driven only from flops.
REQ-016 R-type (op 000000) funct -> EALUC: 100000 add 0010, 100001 addu 0011, 100010 sub 0110, 100011 subu 1110, 100100 and 0000, 100101 or 0001, 100110 xor 1100, 101010 slt 0111, 101011 sltu 0101, 000000 sll 1000, 000010 srl 1001.
REQ-017 I-type op -> EALUC: addi 001000 0010, addiu 001001 0011, slti 001010 0111, sltiu 001011 0101, andi 001100 0000, ori 001101 0001, xori 001110 1100, lui 001111 1111, lw 100011 0010, sw 101011 0010.
REQ-018 Operands: R-type non-shift EXA=A, EXB=B; sll/srl EXA=B, EXB=sign-extend(dinst[15:0]) so EXB[10:6]=shamt; andi/ori/xori EXB=zero-extend(imm); all other I-type EXB=sign-extend(imm); I-type EXA=A.
REQ-019 Destination: R-type ern=dinst[15:11]; I-type ern=dinst[20:16]; ewreg=1 except sw, illegal, bubble; ewreg forced 0 when ern==0.
REQ-020 Illegal op or funct: ebad=1, EALUC=0010, ewreg=0, evalid=dvalid; operands loaded per REQ-018 R-type rule.
REQ-021 Bubble: evalid=0, ewreg=0, ebad=0, ern=0, EALUC=0010, EXA=EXB=0; loaded when dvalid=0 or flush=1.
REQ-022 Priority per edge: reset > flush > stall > normal load; flush with stall loads bubble.
REQ-023 stall=1 (no flush): every output register holds its value; dinst/da/db ignored.

Reset
REQ-024 resetn=0 at a rising edge loads the bubble of REQ-021 into all outputs, regardless of stall/flush/dvalid.
REQ-025 Reset asserted mid-stall discards the held instruction; first post-reset edge with resetn=1 loads normally.
REQ-026 No asynchronous path from resetn to any output.

Configuration
REQ-027 Macro IDEX_FWD_EN defined: A selects malu when mwreg=1, mrn!=0, mrn==rs; else wdata when wwreg=1, wrn!=0, wrn==rs; else da; B identically with rt and db; EX/MEM wins over MEM/WB.
REQ-028 IDEX_FWD_EN undefined: A=da, B=db; forwarding ports present but ignored; no other behaviour changes.

Verification
REQ-029 resetn=0 one edge with dvalid=1, dinst=add -> evalid=0, ewreg=0, EALUC=0010, EXA=EXB=0, ern=0.
REQ-030 dinst=0x00430820 (add r1,r2,r3), da=5, db=7 -> next edge EALUC=0010, EXA=5, EXB=7, ern=1, ewreg=1, evalid=1.
REQ-031 dinst=0x00021080 (sll r2,r2,2), db=0x3 -> EALUC=1000, EXA=3, EXB[10:6]=2; dinst=0x3C01ABCD (lui) -> EALUC=1111, EXB=0xFFFFABCD, ern=1.
REQ-032 ori r1,r0,0x8000 -> EXB=0x00008000; slti with imm 0x8000 -> EXB=0xFFFF8000; sw -> ewreg=0; op 111111 -> ebad=1, ewreg=0.
REQ-033 stall=1 for 3 edges with changing dinst -> outputs constant; stall=1 and flush=1 -> bubble next edge.
REQ-034 IDEX_FWD_EN: rs=2, mwreg=1, mrn=2, malu=0x11, wwreg=1, wrn=2, wdata=0x22 -> EXA=0x11; mrn=0 -> EXA=0x22; without macro -> EXA=da.
